// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus bundle for the system-identification register block.
// A read sampled high at a rising edge returns readdata with readdatavalid one cycle later; a write commits at that same edge; there is no waitrequest.
interface sysid_regs_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regs.sv
// System-identification register file: ID, timestamp, capabilities, scratch,
// a prescaled 64-bit uptime counter with coherent LO/HI reads, and user words.
module sysid_regs #(
    parameter logic [31:0] ID           = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          NUM_USER     = 4,
    parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_INIT = '0,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
    parameter int          PRESCALE     = 1,
    parameter int          ADDR_W       = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    sysid_regs_if.slave bus,
    output logic        o_tick
);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [31:0] CAPS     = {16'(PRESCALE), 8'(ADDR_W), 8'(NUM_USER)};

    logic [63:0] r_counter;
    logic [15:0] r_prescale;
    logic [31:0] r_hi_shadow;
    logic        r_freeze;
    logic [31:0] r_scratch;
    logic [31:0] r_readdata;
    logic        r_rdvalid;

    logic [31:0] w_addr;
    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_wrap;
    logic        w_inc;
    logic [31:0] w_rdata;

    assign w_addr    = 32'(bus.address);
    assign w_ctrl_wr = bus.write && (w_addr == 32'd6);
    assign w_clear   = w_ctrl_wr && bus.writedata[0];
    assign w_wrap    = (r_prescale == PRE_LAST);
    assign w_inc     = !r_freeze && w_wrap;

    // Tick marks the cycle whose closing edge bumps the counter; a clear in
    // that same cycle pre-empts the increment, so the pulse is suppressed.
    assign o_tick = w_inc && !w_clear && !i_reset;

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            32'd0:   w_rdata = ID;
            32'd1:   w_rdata = TIMESTAMP;
            32'd2:   w_rdata = CAPS;
            32'd3:   w_rdata = r_scratch;
            32'd4:   w_rdata = r_counter[31:0];
            32'd5:   w_rdata = r_hi_shadow;
            32'd6:   w_rdata = {30'd0, r_freeze, 1'b0};
            default: w_rdata = '0;
        endcase
        for (int k = 0; k < NUM_USER; k++) begin
            if (w_addr == 32'(8 + k)) begin
                w_rdata = USER_INIT[32*k +: 32];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_counter   <= '0;
            r_prescale  <= '0;
            r_hi_shadow <= '0;
            r_freeze    <= 1'b0;
            r_scratch   <= SCRATCH_INIT;
            r_readdata  <= '0;
            r_rdvalid   <= 1'b0;
        end else begin
            r_rdvalid <= bus.read;
            if (bus.read) begin
                r_readdata <= w_rdata;
            end

            if (w_clear) begin
                r_counter   <= '0;
                r_prescale  <= '0;
                r_hi_shadow <= '0;
            end else begin
                // HI half is latched from the same sample the LO read returns.
                if (bus.read && (w_addr == 32'd4)) begin
                    r_hi_shadow <= r_counter[63:32];
                end
                if (!r_freeze) begin
                    if (w_wrap) begin
                        r_prescale <= '0;
                        r_counter  <= r_counter + 64'd1;
                    end else begin
                        r_prescale <= r_prescale + 16'd1;
                    end
                end
            end

            if (w_ctrl_wr) begin
                r_freeze <= bus.writedata[1];
            end

            if (bus.write && (w_addr == 32'd3)) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.byteenable[i]) begin
                        r_scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign bus.readdata      = r_readdata;
    assign bus.readdatavalid = r_rdvalid;
endmodule

// File: doc/sysid_regs.md
# sysid_regs

Parametrised Avalon-MM system-identification slave for the Qsys system: a fixed-latency register file exposing a compile-time ID, a build timestamp, a capability word, a byte-writable scratch register, a free-running 64-bit uptime counter with coherent split reads, and N read-only user build words. Software uses it to identify the hardware build, check bus integrity, and measure elapsed time. It sits on the CPU data master alongside the other control slaves.

## Interface
- ID, 32'h0000_0000, system ID value returned at word 0
- TIMESTAMP, 32'h0000_0000, build timestamp returned at word 1
- NUM_USER, 4, number of user words (0..255); 8+NUM_USER <= 2**ADDR_W
- USER_INIT, {NUM_USER*32{1'b0}}, packed user words; word k = USER_INIT[32k+31:32k]
- SCRATCH_INIT, 32'h0000_0000, scratch reset value
- PRESCALE, 1, uptime increments once every PRESCALE clocks (1..65535)
- ADDR_W, 4, word address width
- clock  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, one access per cycle
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  registered read data
- readdatavalid  out  1  high the cycle readdata is valid
- tick  out  1  one-cycle pulse each uptime increment

## Operation
- Register map (word address, access):
  - 0 ID (RO); 1 TIMESTAMP (RO)
  - 2 CAPS (RO): [7:0]=NUM_USER, [15:8]=ADDR_W, [31:16]=PRESCALE
  - 3 SCRATCH (RW); byte lane i written only when byteenable[i]
  - 4 UPTIME_LO (RO): returns counter[31:0]; same cycle copies counter[63:32] into HI_SHADOW
  - 5 UPTIME_HI (RO): returns HI_SHADOW (not live counter)
  - 6 CTRL: bit0 CLEAR (write 1: zero counter, prescaler, HI_SHADOW; reads 0); bit1 FREEZE (RW, 1 halts counting); other bits read 0
  - 7 reserved, reads 0
  - 8..8+NUM_USER-1 user words (RO)
  - any other address reads 0; writes to RO/unmapped addresses ignored, no error
- Prescaler: counts 0..PRESCALE-1 while FREEZE=0; at PRESCALE-1 wraps to 0, counter +1, tick=1. PRESCALE=1: counter +1 every unfrozen cycle.
- Counter wraps 2**64-1 -> 0, no flag.
- FREEZE=1 holds prescaler and counter; tick stays 0.
- CLEAR and increment in same cycle: clear wins, tick=0 that cycle.
- CLEAR and FREEZE written together: both take effect; counter held at 0.

## Timing
- Reset values: readdata=0, readdatavalid=0, tick=0, SCRATCH=SCRATCH_INIT, counter=0, prescaler=0, HI_SHADOW=0, FREEZE=0.
- Read latency exactly 1: read in cycle n -> readdata/readdatavalid in n+1; readdatavalid=0 otherwise; readdata holds last value when not valid. No waitrequest; back-to-back reads every cycle.
- Write takes effect at end of the strobe cycle; a read in the same cycle (any address) returns pre-write value.
- UPTIME_LO read returns counter value at the read cycle; HI_SHADOW captured from the same sample.
- tick asserted in the same cycle the counter register updates (pulse aligned with new value visible next cycle).
- reset asserted mid-access: readdatavalid 0 next cycle; pending read discarded; all state to reset values.
- read and write both high: both performed.

## Test plan
- Reset, read addr 0,1,2 with ID=32'h1234_5678, TIMESTAMP=32'h6000_0000, NUM_USER=4, ADDR_W=4, PRESCALE=1 -> readdata 32'h1234_5678, 32'h6000_0000, 32'h0001_0404, each valid exactly 1 cycle after read.
- Write SCRATCH 32'hFFFF_FFFF be=4'b1111, then 32'h0000_0000 be=4'b0101, read -> 32'hFF00_FF00; read of addr 7 and 15 -> 0.
- Preload counter to 32'hFFFF_FFFE in low half via run/freeze, read LO then HI across carry -> HI matches LO sample (e.g. LO=32'hFFFF_FFFF, HI=0; next pair LO=1, HI=1), never torn.
- PRESCALE=3: count tick over 30 cycles -> 10 pulses, evenly spaced by 3; FREEZE=1 for 9 cycles -> 0 ticks, counter unchanged.
- CLEAR write on a tick cycle -> counter reads 0 next access, tick low that cycle; CTRL reads bit0=0.
- Assert reset while read pending and FREEZE=1, SCRATCH modified -> readdatavalid 0, SCRATCH=SCRATCH_INIT, counter resumes from 0.
